fpdiv_ctrl: RTL and testbench
=============================

Name: fpdiv_ctrl

Overview:
- Control sequencer for the Goldschmidt floating-point divider datapath (mux3/mux4 operand muxes, shared multiplier, registers A/B/C).
- Accepts a start request, drives the operand mux selects and register load enables through the initial-approximation and iteration steps, then pulses done.
- Register C holds the quotient mantissa when done pulses.
- The datapath consumes what this block issues; this block owns all sequencing, multiplier-latency waiting and the divide-by-zero bypass.

Parameters:
- N_ITER, 3, number of quotient (X) refinement multiplies; legal range 1..7.
- MUL_LAT, 0, extra pipeline cycles in the multiplier; legal range 0..3.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request a division; sampled only in IDLE
- d_zero  in  1  divisor-is-zero flag; valid with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- dz  out  1  divide-by-zero status; held until the next accepted start
- sel_muxa  out  2  A-operand select: 00 = regA (K), 01 = d, 10 = initial approximation
- sel_muxb  out  2  B-operand select: 00 = d, 01 = x, 10 = regB (D), 11 = regC (X)
- loada  out  1  load K (ones-complement path) into regA
- loadb  out  1  load D into regB
- loadc  out  1  load X into regC
- iter  out  3  current refinement index, 0-based

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE immediately; the wait counter and iteration counter clear.
  - All outputs take their reset values at once: busy=0, done=0, dz=0, sel_muxa=00, sel_muxb=00, loada/loadb/loadc=0, iter=0.
  - A reset mid-operation abandons the division; no further loads are issued.
- Output decoding:
  - All outputs are Moore-decoded from registered state and counters.
  - No combinational path exists from start or d_zero to any output.
- States: IDLE, INIT_D, INIT_X, IT_X, IT_D, DONE.
- Operation states (INIT_D, INIT_X, IT_X, IT_D):
  - Each lasts MUL_LAT+1 cycles.
  - Selects are held constant for the whole state.
  - Load enables assert only on the final cycle, when the wait counter equals MUL_LAT.
- Per-state decode:
  - INIT_D: sel_muxa=10, sel_muxb=00; loadb and loada on the last cycle (D0 = IA*d, K1 = ~D0).
  - INIT_X: sel_muxa=10, sel_muxb=01; loadc on the last cycle (X0 = IA*x).
  - IT_X: sel_muxa=00, sel_muxb=11; loadc on the last cycle (X = X*K).
  - IT_D: sel_muxa=00, sel_muxb=10; loadb and loada on the last cycle (D = D*K, K = ~D).
- Transitions:
  - IDLE -> INIT_D on start && !d_zero. This clears dz and iter.
  - IDLE -> DONE on start && d_zero. This sets dz and issues no loads.
  - INIT_D -> INIT_X after its last cycle.
  - INIT_X -> IT_X after its last cycle.
  - IT_X -> IT_D if iter < N_ITER-1; otherwise -> DONE.
  - IT_D -> IT_X; iter increments on this transition.
  - DONE -> IDLE unconditionally. done=1 for exactly this cycle; busy=1 in DONE.
- Load counts per division:
  - No divide-by-zero: loadc = N_ITER+1; loadb = N_ITER; loada = N_ITER.
  - Divide-by-zero: no loads.
- Latency: op states = 2*N_ITER+1. From the cycle start is sampled to the done cycle = (2*N_ITER+1)*(MUL_LAT+1)+1 cycles.
- Boundary conditions:
  - start while busy is ignored, including in the DONE cycle.
  - start in the first IDLE cycle after DONE is accepted, giving back-to-back divisions.
  - d_zero is ignored outside IDLE.
  - With N_ITER=1 the sequence is INIT_D, INIT_X, IT_X, DONE, and IT_D is never entered.
- Invariant: at most one of {loadb, loadc} is high in any cycle; loada is high only together with loadb.

Test Plan:
- Default params; start=1 for 1 cycle at cycle 0 -> selects (10,00),(10,01),(00,11),(00,10),(00,11),(00,10),(00,11) in cycles 1..7; done=1 at cycle 8; loadc count 4, loadb count 3, loada count 3.
- MUL_LAT=2, N_ITER=1 -> each op state lasts 3 cycles with the load only on its third cycle; done at cycle 10.
- start with d_zero=1 -> done at cycle 1, dz=1, no loads; dz holds; next start with d_zero=0 clears dz in the cycle after start.
- start pulsed at cycles 3 and 8 during a busy division -> ignored; exactly one done; a start held in the cycle after done begins a new division.
- reset_n driven low mid-IT_D -> outputs go to reset values within the same cycle (before the next edge); after release plus start, the full sequence repeats from INIT_D with iter=0.
- Checker over random starts and d_zero values: the loadb/loadc exclusivity and loada-implies-loadb invariants are never violated, and busy is low only in IDLE.

Source files
------------

// File: rtl/fpdiv_ctrl_if.sv
// fpdiv_ctrl_if
//   Bundles the request/status and datapath-control signals of the
//   Goldschmidt divider sequencer.
//   master : the requester side (drives start/d_zero, observes the rest)
//   slave  : the sequencer side (fpdiv_ctrl)
//   Signals:
//     start     request a division
//     d_zero    divisor-is-zero flag, valid with start
//     busy      high in every state except IDLE
//     done      one-cycle completion pulse
//     dz        divide-by-zero status, held until the next accepted start
//     sel_muxa  A-operand select: 00 regA (K), 01 d, 10 initial approximation
//     sel_muxb  B-operand select: 00 d, 01 x, 10 regB (D), 11 regC (X)
//     loada     load K into regA
//     loadb     load D into regB
//     loadc     load X into regC
//     iter      current refinement index, 0-based
interface fpdiv_ctrl_if;
  logic       start;
  logic       d_zero;
  logic       busy;
  logic       done;
  logic       dz;
  logic [1:0] sel_muxa;
  logic [1:0] sel_muxb;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic [2:0] iter;

  modport master (
    output start, d_zero,
    input  busy, done, dz, sel_muxa, sel_muxb, loada, loadb, loadc, iter
  );

  modport slave (
    input  start, d_zero,
    output busy, done, dz, sel_muxa, sel_muxb, loada, loadb, loadc, iter
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl
//   Control sequencer for the Goldschmidt floating-point divider datapath.
//   On an accepted start it steps through INIT_D, INIT_X and alternating
//   IT_X / IT_D refinement states, driving operand-mux selects and register
//   load enables, then pulses done. A zero divisor skips straight to DONE
//   with dz set and no loads issued.
//   Parameters:
//     N_ITER   number of quotient refinement multiplies (1..7)
//     MUL_LAT  extra multiplier pipeline cycles (0..3)
//   Ports:
//     clk      clock
//     reset_n  asynchronous active-low reset
//     bus      fpdiv_ctrl_if.slave (start/d_zero in; status and controls out)
module fpdiv_ctrl #(
  parameter int N_ITER  = 3,
  parameter int MUL_LAT = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  fpdiv_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_D,
    S_INIT_X,
    S_IT_X,
    S_IT_D,
    S_DONE
  } state_t;

  localparam logic [1:0] LAT_LAST  = 2'(MUL_LAT);
  localparam logic [2:0] ITER_LAST = 3'(N_ITER - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_wait,  w_wait_nxt;
  logic [2:0] r_iter,  w_iter_nxt;
  logic       r_dz,    w_dz_nxt;
  logic       w_last;

  // Final cycle of an operation state: the multiplier result is valid now.
  assign w_last = (r_wait == LAT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_wait  <= 2'd0;
      r_iter  <= 3'd0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_iter  <= w_iter_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_iter_nxt  = r_iter;
    w_dz_nxt    = r_dz;

    case (r_state)
      S_IDLE: begin
        w_wait_nxt = 2'd0;
        if (bus.start) begin
          if (bus.d_zero) begin
            w_state_nxt = S_DONE;
            w_dz_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_INIT_D;
            w_dz_nxt    = 1'b0;
            w_iter_nxt  = 3'd0;
          end
        end
      end
      S_INIT_D, S_INIT_X, S_IT_X, S_IT_D: begin
        if (!w_last) begin
          w_wait_nxt = r_wait + 2'd1;
        end else begin
          w_wait_nxt = 2'd0;
          case (r_state)
            S_INIT_D: w_state_nxt = S_INIT_X;
            S_INIT_X: w_state_nxt = S_IT_X;
            S_IT_X:   w_state_nxt = (r_iter < ITER_LAST) ? S_IT_D : S_DONE;
            default: begin
              w_state_nxt = S_IT_X;
              w_iter_nxt  = r_iter + 3'd1;
            end
          endcase
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode: selects held for the whole state, loads only on
  // the final wait cycle.
  always_comb begin
    bus.busy     = (r_state != S_IDLE);
    bus.done     = (r_state == S_DONE);
    bus.dz       = r_dz;
    bus.iter     = r_iter;
    bus.sel_muxa = 2'b00;
    bus.sel_muxb = 2'b00;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;

    case (r_state)
      S_INIT_D: begin
        bus.sel_muxa = 2'b10;
        bus.sel_muxb = 2'b00;
        bus.loadb    = w_last;
        bus.loada    = w_last;
      end
      S_INIT_X: begin
        bus.sel_muxa = 2'b10;
        bus.sel_muxb = 2'b01;
        bus.loadc    = w_last;
      end
      S_IT_X: begin
        bus.sel_muxa = 2'b00;
        bus.sel_muxb = 2'b11;
        bus.loadc    = w_last;
      end
      S_IT_D: begin
        bus.sel_muxa = 2'b00;
        bus.sel_muxb = 2'b10;
        bus.loadb    = w_last;
        bus.loada    = w_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
module tb_fpdiv_ctrl;

  localparam int N0 = 3;
  localparam int L0 = 0;
  localparam int N1 = 1;
  localparam int L1 = 2;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] sela;
    logic [1:0] selb;
    logic       la;
    logic       lb;
    logic       lc;
    logic [2:0] iter;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fpdiv_ctrl_if if0 ();
  fpdiv_ctrl_if if1 ();

  fpdiv_ctrl #(.N_ITER(N0), .MUL_LAT(L0)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  fpdiv_ctrl #(.N_ITER(N1), .MUL_LAT(L1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: per-DUT queue of expected output records for the
  // upcoming cycles of the division in flight; empty queue means IDLE.
  rec_t q0[$];
  rec_t q1[$];
  logic dz_m[2];
  logic [2:0] last_iter[2];
  int cnt_la[2], cnt_lb[2], cnt_lc[2], cnt_done[2], done_cyc[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t obs_of(input int d);
    rec_t r;
    if (d == 0)
      r = {if0.busy, if0.done, if0.sel_muxa, if0.sel_muxb, if0.loada, if0.loadb, if0.loadc, if0.iter};
    else
      r = {if1.busy, if1.done, if1.sel_muxa, if1.sel_muxb, if1.loada, if1.loadb, if1.loadc, if1.iter};
    return r;
  endfunction

  function automatic logic dz_of(input int d);
    return (d == 0) ? if0.dz : if1.dz;
  endfunction

  task automatic qpush(input int d, input rec_t r);
    if (d == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // One operation state: lat+1 cycles, selects constant, loads on the last.
  task automatic push_op(input int d, input int lat, input logic [1:0] a, input logic [1:0] b,
                         input logic la, input logic lb, input logic lc, input int it);
    rec_t r;
    for (int c = 0; c <= lat; c++) begin
      r      = '0;
      r.busy = 1'b1;
      r.sela = a;
      r.selb = b;
      r.la   = la && (c == lat);
      r.lb   = lb && (c == lat);
      r.lc   = lc && (c == lat);
      r.iter = 3'(it);
      qpush(d, r);
    end
  endtask

  task automatic push_div(input int d, input int n, input int lat);
    rec_t r;
    push_op(d, lat, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 0);
    push_op(d, lat, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 0);
    for (int k = 0; k < n; k++) begin
      push_op(d, lat, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, k);
      if (k < n - 1) push_op(d, lat, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, k);
    end
    r      = '0;
    r.busy = 1'b1;
    r.done = 1'b1;
    r.iter = 3'(n - 1);
    qpush(d, r);
  endtask

  task automatic step(input int d, input logic st, input logic dzin);
    rec_t e, o, r;
    int   sz;
    int   n, lat;
    n   = (d == 0) ? N0 : N1;
    lat = (d == 0) ? L0 : L1;
    sz  = (d == 0) ? q0.size() : q1.size();
    o   = obs_of(d);
    if (sz > 0) e = (d == 0) ? q0[0] : q1[0];
    else begin
      e      = '0;
      e.iter = last_iter[d];
    end
    check($sformatf("dut%0d_outputs_cyc%0d", d, cyc), 32'(o), 32'(e));
    check($sformatf("dut%0d_dz_cyc%0d", d, cyc), 32'(dz_of(d)), 32'(dz_m[d]));
    check($sformatf("dut%0d_load_invariant_cyc%0d", d, cyc),
          32'(!(o.lb && o.lc) && (!o.la || o.lb)), 32'd1);
    cnt_la[d]   += int'(o.la);
    cnt_lb[d]   += int'(o.lb);
    cnt_lc[d]   += int'(o.lc);
    cnt_done[d] += int'(o.done);
    if (o.done) done_cyc[d] = cyc;
    if (sz > 0) begin
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end else if (st) begin
      if (dzin) begin
        r      = '0;
        r.busy = 1'b1;
        r.done = 1'b1;
        r.iter = last_iter[d];
        qpush(d, r);
        dz_m[d] = 1'b1;
      end else begin
        push_div(d, n, lat);
        dz_m[d]      = 1'b0;
        last_iter[d] = 3'(n - 1);
      end
    end
  endtask

  task automatic tick(input logic st, input logic dzin);
    @(negedge clk);
    step(0, st, dzin);
    step(1, st, dzin);
    if0.start  = st;
    if0.d_zero = dzin;
    if1.start  = st;
    if1.d_zero = dzin;
    cyc++;
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      cnt_la[d] = 0; cnt_lb[d] = 0; cnt_lc[d] = 0; cnt_done[d] = 0; done_cyc[d] = -1;
    end
  endtask

  task automatic reset_model();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      dz_m[d]      = 1'b0;
      last_iter[d] = 3'd0;
    end
  endtask

  initial begin
    int c0;
    if0.start = 1'b0; if0.d_zero = 1'b0;
    if1.start = 1'b0; if1.d_zero = 1'b0;
    reset_model();
    clear_counts();

    // Reset state
    #1;
    check("reset_u0_outputs", 32'(obs_of(0)), 32'd0);
    check("reset_u1_outputs", 32'(obs_of(1)), 32'd0);
    check("reset_u0_dz", 32'(if0.dz), 32'd0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset_n = 1'b1;

    // Basic division on both configurations
    clear_counts();
    c0 = cyc;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    check("u0_latency", 32'(done_cyc[0] - c0), 32'((2 * N0 + 1) * (L0 + 1) + 1));
    check("u1_latency", 32'(done_cyc[1] - c0), 32'((2 * N1 + 1) * (L1 + 1) + 1));
    check("u0_loadc_count", 32'(cnt_lc[0]), 32'd4);
    check("u0_loadb_count", 32'(cnt_lb[0]), 32'd3);
    check("u0_loada_count", 32'(cnt_la[0]), 32'd3);
    check("u1_loadc_count", 32'(cnt_lc[1]), 32'd2);
    check("u1_loadb_count", 32'(cnt_lb[1]), 32'd1);
    check("u0_done_count", 32'(cnt_done[0]), 32'd1);

    // Divide by zero, dz held, then cleared by a normal start
    clear_counts();
    c0 = cyc;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    check("dz_u0_done_cycle", 32'(done_cyc[0] - c0), 32'd1);
    check("dz_u0_no_loads", 32'(cnt_la[0] + cnt_lb[0] + cnt_lc[0]), 32'd0);
    check("dz_u0_held", 32'(if0.dz), 32'd1);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);

    // Starts while busy are ignored; start right after DONE is accepted
    clear_counts();
    for (int i = 0; i < 17; i++) tick((i == 0) || (i == 3) || (i == 8) || (i == 9), 1'b0);
    check("busy_start_u0_done_count", 32'(cnt_done[0]), 32'd1);
    for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
    check("busy_start_u0_second_done", 32'(cnt_done[0]), 32'd2);

    // Asynchronous reset in the middle of IT_D
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("u0_in_IT_D_selb", 32'(if0.sel_muxb), 32'd2);
    reset_n = 1'b0;
    #1;
    check("async_reset_u0_outputs", 32'(obs_of(0)), 32'd0);
    check("async_reset_u1_outputs", 32'(obs_of(1)), 32'd0);
    check("async_reset_u0_dz", 32'(if0.dz), 32'd0);
    reset_model();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    #2 reset_n = 1'b1;
    clear_counts();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    check("after_reset_u0_loadc_count", 32'(cnt_lc[0]), 32'd4);

    // Random starts and divisor-zero flags
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
